// File: rtl/mem_arbiter.sv
// Round-robin N-port arbiter sharing one physical-memory line port among cache clients.
// One transaction at a time: grant in IDLE, hold the request in BUSY, pulse the winner in RESP.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_read,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_resp,
  output logic [LINE_WIDTH-1:0]           port_rdata,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_WIDTH-1:0]           pmem_address,
  output logic [LINE_WIDTH-1:0]           pmem_wdata,
  input  logic [LINE_WIDTH-1:0]           pmem_rdata,
  input  logic                            pmem_resp
);

  localparam int IDX_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_g;
  logic [IDX_W-1:0]        r_ptr;
  logic                    r_op_write;
  logic [ADDR_WIDTH-1:0]   r_pmem_address;
  logic [LINE_WIDTH-1:0]   r_pmem_wdata;
  logic [LINE_WIDTH-1:0]   r_port_rdata;

  logic [NUM_PORTS-1:0]    w_req;
  logic [IDX_W-1:0]        w_win;
  logic                    w_found;
  logic [IDX_W:0]          w_sum;

  assign w_req = port_read | port_write;

  // Scan from the highest offset down so the port closest to ptr is the last one kept.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_PORTS)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
      end
      if (w_req[w_sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    port_resp    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        pmem_read  = !r_op_write;
        pmem_write = r_op_write;
        if (pmem_resp) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        port_resp    = NUM_PORTS'(1) << r_g;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Write wins when a port raises both read and write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g            <= '0;
      r_ptr          <= '0;
      r_op_write     <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_port_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_g            <= w_win;
            r_op_write     <= port_write[w_win];
            r_pmem_address <= port_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_pmem_wdata   <= port_wdata[w_win*LINE_WIDTH +: LINE_WIDTH];
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            r_port_rdata <= pmem_rdata;
          end
        end
        RESP: begin
          r_ptr <= (r_g == LAST_IDX) ? '0 : r_g + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign port_rdata   = r_port_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with three ports: directed table, corner sequences,
// and randomized traffic checked against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     port_read;
  logic [NP-1:0]     port_write;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*LW-1:0]  port_wdata;
  logic [NP-1:0]     port_resp;
  logic [LW-1:0]     port_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [AW-1:0]     pmem_address;
  logic [LW-1:0]     pmem_wdata;
  logic [LW-1:0]     pmem_rdata;
  logic              pmem_resp;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_read    (port_read),
    .port_write   (port_write),
    .port_addr    (port_addr),
    .port_wdata   (port_wdata),
    .port_resp    (port_resp),
    .port_rdata   (port_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0] rd_v;
  logic [NP-1:0] wr_v;
  logic [AW-1:0] addr_v  [NP];
  logic [LW-1:0] wdata_v [NP];
  int            n_vec = 0;
  int            n_err = 0;
  int            mem_lat = 1;
  logic [LW-1:0] next_line = '0;

  always_comb begin
    port_read  = rd_v;
    port_write = wr_v;
    port_addr  = '0;
    port_wdata = '0;
    for (int i = 0; i < NP; i++) begin
      port_addr[i*AW +: AW]  = addr_v[i];
      port_wdata[i*LW +: LW] = wdata_v[i];
    end
  end

  // Memory: responds on the mem_lat-th cycle a request is seen.
  initial begin
    int cnt;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !(pmem_read || pmem_write)) begin
        cnt       = 0;
        pmem_resp = 1'b0;
      end else begin
        cnt++;
        pmem_resp = (cnt == mem_lat);
        if (pmem_resp) pmem_rdata = next_line;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Reference arbitration: first requester scanning ptr, ptr+1, ... mod NP.
  function automatic int model_pick(input int ptr, input logic [NP-1:0] req);
    for (int k = 0; k < NP; k++) begin
      if (req[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  task automatic run_txn(input string nm, input int exp_port, input bit exp_wr,
                         input int lat, input logic [LW-1:0] line);
    int wait_c;
    int act_c;
    logic [NP-1:0] one_hot;
    mem_lat   = lat;
    next_line = line;
    wait_c    = 0;
    do begin
      @(posedge clk); #1;
      wait_c++;
    end while (!(pmem_read || pmem_write) && wait_c < 20);
    if (!(pmem_read || pmem_write)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no pmem request want request within 20 cycles", nm);
      return;
    end
    chk({nm, "_grant_lat"}, LW'(wait_c), LW'(1));
    chk({nm, "_op"}, LW'({pmem_write, pmem_read}), exp_wr ? LW'(2'b10) : LW'(2'b01));
    if (exp_wr) chk({nm, "_wdata"}, pmem_wdata, wdata_v[exp_port]);
    act_c = 0;
    while ((pmem_read || pmem_write) && act_c < 50) begin
      act_c++;
      chk({nm, "_addr"}, LW'(pmem_address), LW'(addr_v[exp_port]));
      chk({nm, "_resp_busy"}, LW'(port_resp), LW'(0));
      @(posedge clk); #1;
    end
    one_hot = NP'(1) << exp_port;
    chk({nm, "_busy_cycles"}, LW'(act_c), LW'(lat));
    chk({nm, "_resp"}, LW'(port_resp), LW'(one_hot));
    chk({nm, "_rdata"}, port_rdata, line);
    @(posedge clk); #1;
    chk({nm, "_resp_off"}, LW'(port_resp), LW'(0));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_rdata", port_rdata, '0);
    chk("rst_pmem", LW'({pmem_read, pmem_write}), LW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NP-1:0] rd;
    logic [NP-1:0] wr;
    int            win;
    bit            wr_op;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ptr_m;
    int win;
    int wait_c;
    int op;

    // Expected winners follow round-robin from ptr=0 after reset.
    tbl[0] = '{rd: 3'b001, wr: 3'b000, win: 0, wr_op: 1'b0};
    tbl[1] = '{rd: 3'b001, wr: 3'b000, win: 0, wr_op: 1'b0};
    tbl[2] = '{rd: 3'b101, wr: 3'b000, win: 2, wr_op: 1'b0};
    tbl[3] = '{rd: 3'b000, wr: 3'b010, win: 1, wr_op: 1'b1};
    tbl[4] = '{rd: 3'b011, wr: 3'b000, win: 0, wr_op: 1'b0};
    tbl[5] = '{rd: 3'b010, wr: 3'b010, win: 1, wr_op: 1'b1};
    tbl[6] = '{rd: 3'b000, wr: 3'b111, win: 2, wr_op: 1'b1};
    tbl[7] = '{rd: 3'b110, wr: 3'b000, win: 1, wr_op: 1'b0};

    rst_n = 1'b0;
    rd_v  = '0;
    wr_v  = '0;
    for (int i = 0; i < NP; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pmem_rw", LW'({pmem_read, pmem_write}), LW'(0));
    chk("reset_addr", LW'(pmem_address), LW'(0));
    chk("reset_wdata", pmem_wdata, '0);
    chk("reset_resp", LW'(port_resp), LW'(0));
    chk("reset_rdata", port_rdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read from port 0, memory answers on the third cycle.
    addr_v[0] = 32'h0000_1000;
    rd_v      = 3'b001;
    run_txn("iread", 0, 1'b0, 3, {32{8'hA5}});
    rd_v = '0;
    $display("txn iread done");

    // Simultaneous read on port 0 and write on port 1 right after reset.
    reset_pulse();
    addr_v[0]  = 32'h0000_2000;
    addr_v[1]  = 32'h0000_3000;
    wdata_v[1] = rnd_line();
    rd_v       = 3'b001;
    wr_v       = 3'b010;
    run_txn("simul_p0", 0, 1'b0, 1, rnd_line());
    rd_v = '0;
    run_txn("simul_p1", 1, 1'b1, 2, rnd_line());
    wr_v = '0;
    $display("txn simultaneous done");

    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NP; p++) begin
        addr_v[p]  = 32'h0000_4000 + 32'(i*16 + p*4);
        wdata_v[p] = rnd_line();
      end
      rd_v = tbl[i].rd;
      wr_v = tbl[i].wr;
      run_txn($sformatf("tbl%0d", i), tbl[i].win, tbl[i].wr_op, (i % 4) + 1, rnd_line());
      rd_v = '0;
      wr_v = '0;
      $display("txn tbl%0d rd=%b wr=%b expected port %0d", i, tbl[i].rd, tbl[i].wr, tbl[i].win);
    end

    // Address hold: ptr is 2, port 2 changes its address mid-transaction.
    addr_v[2] = 32'h0000_0100;
    rd_v      = 3'b100;
    mem_lat   = 4;
    next_line = rnd_line();
    wait_c    = 0;
    do begin
      @(posedge clk); #1;
      wait_c++;
    end while (!pmem_read && wait_c < 20);
    chk("hold_started", LW'(pmem_read), LW'(1));
    addr_v[2] = 32'h0000_0200;
    wait_c    = 0;
    while (pmem_read && wait_c < 20) begin
      wait_c++;
      chk("hold_addr", LW'(pmem_address), LW'(32'h0000_0100));
      @(posedge clk); #1;
    end
    chk("hold_resp", LW'(port_resp), LW'(3'b100));
    rd_v = '0;
    @(posedge clk); #1;
    $display("txn address hold done");

    // Wrap after port 2: ptr must be 0, so port 0 wins over port 1.
    addr_v[0] = 32'h0000_5000;
    addr_v[1] = 32'h0000_5100;
    rd_v      = 3'b011;
    run_txn("wrap", 0, 1'b0, 1, rnd_line());
    rd_v = '0;
    $display("txn wrap done");

    // Reset in BUSY while ptr=1; afterwards ptr must be 0 again.
    addr_v[2] = 32'h0000_6000;
    rd_v      = 3'b100;
    mem_lat   = 6;
    wait_c    = 0;
    do begin
      @(posedge clk); #1;
      wait_c++;
    end while (!pmem_read && wait_c < 20);
    chk("rstbusy_started", LW'(pmem_read), LW'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstbusy_pmem_drop", LW'({pmem_read, pmem_write}), LW'(0));
    rd_v = '0;
    @(posedge clk); #1;
    chk("rstbusy_no_resp", LW'(port_resp), LW'(0));
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rstbusy_no_resp_after", LW'(port_resp), LW'(0));
    end
    addr_v[0] = 32'h0000_7000;
    addr_v[2] = 32'h0000_7200;
    rd_v      = 3'b101;
    run_txn("rstbusy_fresh", 0, 1'b0, 2, rnd_line());
    rd_v = '0;
    $display("txn reset mid-busy done");

    // All three ports requesting continuously from ptr=0.
    reset_pulse();
    rd_v = 3'b111;
    for (int t = 0; t < 6; t++) begin
      run_txn($sformatf("rr%0d", t), t % NP, 1'b0, 1 + (t % 2), rnd_line());
      $display("txn rr%0d expected port %0d", t, t % NP);
    end
    rd_v = '0;
    @(posedge clk); #1;

    // Randomized traffic against the round-robin model.
    reset_pulse();
    ptr_m = 0;
    for (int t = 0; t < 200; t++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(rd_v[p] | wr_v[p]) && ($urandom_range(0, 1) == 1)) begin
          op         = $urandom_range(0, 2);
          rd_v[p]    = (op != 1);
          wr_v[p]    = (op != 0);
          addr_v[p]  = $urandom;
          wdata_v[p] = rnd_line();
        end
      end
      if ((rd_v | wr_v) == '0) begin
        op         = $urandom_range(0, NP - 1);
        rd_v[op]   = 1'b1;
        addr_v[op] = $urandom;
      end
      win = model_pick(ptr_m, rd_v | wr_v);
      run_txn($sformatf("rnd%0d", t), win, wr_v[win], $urandom_range(1, 4), rnd_line());
      $display("txn rnd%0d port %0d write=%0d", t, win, wr_v[win]);
      rd_v[win] = 1'b0;
      wr_v[win] = 1'b0;
      ptr_m     = (win + 1) % NP;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
